// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback path: one buffered write entry and the x0 index.
package wb_pkg;

    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DATA_W = 32;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for MEM writebacks; push is ignored when full, pop is ignored when empty.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  wb_entry_t        i_data,
    input  logic             i_pop,
    output wb_entry_t        o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges ALU and buffered MEM writebacks into one registered register-file write port.
// Optional anti-starvation drain of the MEM buffer is enabled by defining WB_STARVE_EN.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = WB_ADDR_W,
    parameter int unsigned DATA_WIDTH    = WB_DATA_W,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned STARVE_LIMIT  = 8,
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_alu_valid,
    output logic                     o_alu_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_alu_rd,
    input  logic [DATA_WIDTH-1:0]    i_alu_result,
    input  logic                     i_mem_valid,
    output logic                     o_mem_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_mem_rd,
    input  logic [DATA_WIDTH-1:0]    i_mem_data,
    output logic                     o_we3,
    output logic [ADDRESS_WIDTH-1:0] o_a3,
    output logic [DATA_WIDTH-1:0]    o_wd3,
    output logic                     o_pending,
    output logic [CNT_W-1:0]         o_fifo_count
);

    if (ADDRESS_WIDTH != WB_ADDR_W || DATA_WIDTH != WB_DATA_W) begin : g_bad_width
        $error("wb_write_arbiter: widths must match wb_pkg::wb_entry_t");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_write_arbiter: FIFO_DEPTH must be a power of two >= 2");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("wb_write_arbiter: STARVE_LIMIT must be >= 1");
    end

    logic                     r_we3;
    logic [ADDRESS_WIDTH-1:0] r_a3;
    logic [DATA_WIDTH-1:0]    r_wd3;

    logic      w_alu_ready;
    logic      w_alu_wr;
    logic      w_push;
    logic      w_pop;
    logic      w_fifo_full;
    logic      w_fifo_empty;
    wb_entry_t w_mem_entry;
    wb_entry_t w_head;

    assign w_mem_entry = '{rd: i_mem_rd, data: i_mem_data};

    // x0 handshakes still complete; they simply never reach the write stream or the buffer.
    assign w_alu_wr = i_alu_valid && w_alu_ready && (i_alu_rd != REG_ZERO);
    assign w_push   = i_mem_valid && !w_fifo_full && (i_mem_rd != REG_ZERO);
    assign w_pop    = !w_alu_wr && !w_fifo_empty;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_mem_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (o_fifo_count)
    );

`ifdef WB_STARVE_EN
    localparam int unsigned SCNT_W = $clog2(STARVE_LIMIT + 1);

    logic [SCNT_W-1:0] r_starve;
    logic              w_force_drain;

    assign w_force_drain = (r_starve == SCNT_W'(STARVE_LIMIT));
    assign w_alu_ready   = !w_force_drain;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve <= '0;
        end else if (w_pop || w_fifo_empty) begin
            r_starve <= '0;
        end else if (w_alu_wr && !w_force_drain) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    assign w_alu_ready = 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else begin
            r_we3 <= w_alu_wr || w_pop;
            if (w_alu_wr) begin
                r_a3  <= i_alu_rd;
                r_wd3 <= i_alu_result;
            end else if (w_pop) begin
                r_a3  <= w_head.rd;
                r_wd3 <= w_head.data;
            end
        end
    end

    assign o_alu_ready = w_alu_ready;
    assign o_mem_ready = !w_fifo_full;
    assign o_we3       = r_we3;
    assign o_a3        = r_a3;
    assign o_wd3       = r_wd3;
    assign o_pending   = !w_fifo_empty || r_we3;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's outputs; a monitor compares.
module tb_wb_write_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          i_rst;
    logic          i_alu_valid;
    logic          o_alu_ready;
    logic [AW-1:0] i_alu_rd;
    logic [DW-1:0] i_alu_result;
    logic          i_mem_valid;
    logic          o_mem_ready;
    logic [AW-1:0] i_mem_rd;
    logic [DW-1:0] i_mem_data;
    logic          o_we3;
    logic [AW-1:0] o_a3;
    logic [DW-1:0] o_wd3;
    logic          o_pending;
    logic [CW-1:0] o_fifo_count;

    wb_write_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_alu_valid  (i_alu_valid),
        .o_alu_ready  (o_alu_ready),
        .i_alu_rd     (i_alu_rd),
        .i_alu_result (i_alu_result),
        .i_mem_valid  (i_mem_valid),
        .o_mem_ready  (o_mem_ready),
        .i_mem_rd     (i_mem_rd),
        .i_mem_data   (i_mem_data),
        .o_we3        (o_we3),
        .o_a3         (o_a3),
        .o_wd3        (o_wd3),
        .o_pending    (o_pending),
        .o_fifo_count (o_fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] a3;
        logic [DW-1:0] wd3;
        int            count;
        logic          alu_rdy;
        logic          mem_rdy;
        logic          pending;
    } snap_t;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    snap_t exp_q[$];
    ent_t  buf_m[$];

    logic          m_we;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd3;
    int            m_starve;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic model_alu_ready();
`ifdef WB_STARVE_EN
        return (m_starve != LIMIT);
`else
        return 1'b1;
`endif
    endfunction

    // Monitor: each negedge shows the outputs the model predicted for this cycle.
    snap_t e;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("we3", 32'(o_we3), 32'(e.we));
            chk("a3", 32'(o_a3), 32'(e.a3));
            chk("wd3", o_wd3, e.wd3);
            chk("fifo_count", 32'(o_fifo_count), 32'(e.count));
            chk("alu_ready", 32'(o_alu_ready), 32'(e.alu_rdy));
            chk("mem_ready", 32'(o_mem_ready), 32'(e.mem_rdy));
            chk("pending", 32'(o_pending), 32'(e.pending));
        end
    end

    // Called just after a posedge: drive one cycle, record the expected outputs, advance the model.
    task automatic step(input bit rst, input bit av, input logic [AW-1:0] ard,
                        input logic [DW-1:0] ares, input bit mv, input logic [AW-1:0] mrd,
                        input logic [DW-1:0] md);
        snap_t s;
        ent_t  head;
        bit    alu_rdy, mem_rdy, alu_w, pop;
        int    size0;
        i_rst        = rst;
        i_alu_valid  = av;
        i_alu_rd     = ard;
        i_alu_result = ares;
        i_mem_valid  = mv;
        i_mem_rd     = mrd;
        i_mem_data   = md;

        alu_rdy   = model_alu_ready();
        mem_rdy   = (buf_m.size() != DEPTH);
        s.we      = m_we;
        s.a3      = m_a3;
        s.wd3     = m_wd3;
        s.count   = buf_m.size();
        s.alu_rdy = alu_rdy;
        s.mem_rdy = mem_rdy;
        s.pending = (buf_m.size() != 0) || m_we;
        exp_q.push_back(s);

        if (rst) begin
            buf_m.delete();
            m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_starve = 0;
        end else begin
            size0 = buf_m.size();
            alu_w = av && alu_rdy && (ard != 0);
            pop   = !alu_w && (size0 != 0);
            if (pop) head = buf_m.pop_front();
            if (mv && mem_rdy && mrd != 0) buf_m.push_back('{rd: mrd, data: md});
            if (pop || size0 == 0) m_starve = 0;
            else if (alu_w && m_starve < LIMIT) m_starve++;
            m_we = alu_w || pop;
            if (alu_w) begin
                m_a3 = ard; m_wd3 = ares;
            end else if (pop) begin
                m_a3 = head.rd; m_wd3 = head.data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0);
    endtask

    initial begin
        logic [AW-1:0] ard, mrd;
        i_rst = 1'b1;
        i_alu_valid = 1'b0; i_alu_rd = '0; i_alu_result = '0;
        i_mem_valid = 1'b0; i_mem_rd = '0; i_mem_data = '0;
        m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_starve = 0;
        repeat (2) @(posedge clk);
        #1;

        // Single ALU write, then x0 ALU write, then simultaneous ALU and MEM.
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
        idle(2);
        step(0, 1, 5'd0, 32'h12345678, 0, '0, '0);
        idle(2);
        step(0, 1, 5'd7, 32'd1, 1, 5'd3, 32'h11);
        idle(3);

        // ALU busy every cycle while five MEM offers arrive: buffer fills, then drains in order.
        for (int i = 0; i < 6; i++)
            step(0, 1, 5'(i + 1), $urandom, (i < 5), 5'(10 + i), $urandom);
        idle(6);

        // Long ALU run with a non-empty buffer (exercises the drain when enabled).
        for (int i = 0; i < 2; i++) step(0, 1, 5'd9, $urandom, 1, 5'(20 + i), $urandom);
        for (int i = 0; i < 12; i++) step(0, 1, 5'd9, $urandom, 0, '0, '0);
        idle(4);

        // Buffer three entries, then reset: they must never be written.
        for (int i = 0; i < 3; i++) step(0, 1, 5'd4, $urandom, 1, 5'(25 + i), $urandom);
        step(1, 0, '0, '0, 0, '0, '0);
        idle(5);

        // MEM x0 offer is accepted and dropped.
        step(0, 0, '0, '0, 1, 5'd0, 32'hCAFE);
        idle(3);

        for (int i = 0; i < 600; i++) begin
            ard = ($urandom_range(0, 3) == 0) ? '0 : 5'($urandom_range(1, 31));
            mrd = ($urandom_range(0, 5) == 0) ? '0 : 5'($urandom_range(1, 31));
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), ard, $urandom,
                 ($urandom_range(0, 1) == 1), mrd, $urandom);
        end
        idle(8);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
